// File: rtl/rv_fetch_q.sv
// -----------------------------------------------------------------------------
// rv_fetch_q -- RISC-V instruction fetch stage with a decoupled queue.
//
// Issues one single-word read at a time on the instruction bus, buffers the
// returned words in a small FIFO, and hands them to decode over a valid/ready
// handshake. Each returned word is predecoded so that JAL and backward
// conditional branches redirect fetch immediately (static taken prediction).
// Execute (i_pc_select) and the CSR unit (i_ebreak) can redirect fetch; a
// redirect flushes the queue and drops any bus completion in that cycle.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_pc_select, i_pc_target  execute redirect request and address
//   i_ebreak, i_pc_trap       trap redirect request and vector
//   i_instruction, i_ack      bus read data / completion
//   o_addr, o_cyc             bus address (fetch pc) / request
//   o_valid, i_ready          decode handshake for the queue head
//   o_instruction, o_pc       head word and its address
//   o_branch_pred             head was predicted taken
//   o_pred_target             predicted target of head (0 if not predicted)
//   o_count                   queue occupancy
// -----------------------------------------------------------------------------
module rv_fetch_q #(
  parameter logic [31:0] RESET_ADDR        = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH_LOG2    = 2,
  parameter bit          BRANCH_PREDICTION = 1'b1,
  parameter bit          EXTENSION_Zicsr   = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_pc_select,
  input  logic [31:0]               i_pc_target,
  input  logic                      i_ebreak,
  input  logic [31:0]               i_pc_trap,
  input  logic [31:0]               i_instruction,
  input  logic                      i_ack,
  output logic [31:0]               o_addr,
  output logic                      o_cyc,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [31:0]               o_instruction,
  output logic [31:0]               o_pc,
  output logic                      o_branch_pred,
  output logic [31:0]               o_pred_target,
  output logic [BUF_DEPTH_LOG2:0]   o_count
);

  localparam int unsigned DEPTH     = 2 ** BUF_DEPTH_LOG2;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  typedef logic [BUF_DEPTH_LOG2-1:0] ptr_t;
  typedef logic [BUF_DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t FULL_COUNT = cnt_t'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] target;
  } entry_t;

  // State
  logic [31:0] pc_q, pc_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        count_q, count_d;
  entry_t      mem_q [DEPTH];

  // Control
  logic        trap, redirect, accept, pop;
  entry_t      head, push_entry;

  // Predecode
  logic [31:0] j_imm, b_imm, cand_target;
  logic        is_jal, is_bwd_branch, predict_taken;

  // Trap only counts when the CSR extension is present; it outranks execute.
  assign trap     = EXTENSION_Zicsr & i_ebreak;
  assign redirect = trap | i_pc_select;

  // The request is held off while full, so a push can never overflow.
  assign o_cyc   = ~i_reset & ~redirect & (count_q != FULL_COUNT);
  assign o_addr  = pc_q;
  assign accept  = o_cyc & i_ack;
  assign o_valid = (count_q != '0) & ~redirect;
  assign pop     = o_valid & i_ready;
  assign o_count = count_q;

  assign head          = mem_q[rd_ptr_q];
  assign o_instruction = o_valid ? head.instr  : NOP;
  assign o_pc          = o_valid ? head.pc     : 32'h0;
  assign o_branch_pred = o_valid & head.pred;
  assign o_pred_target = o_valid ? head.target : 32'h0;

  // Static predictor: JAL always, conditional branches only when backward
  // (sign bit of the B-immediate set). Misaligned targets fall through.
  always_comb begin
    j_imm = {{12{i_instruction[31]}}, i_instruction[19:12], i_instruction[20],
             i_instruction[30:21], 1'b0};
    b_imm = {{20{i_instruction[31]}}, i_instruction[7], i_instruction[30:25],
             i_instruction[11:8], 1'b0};
    is_jal        = (i_instruction[6:0] == OP_JAL);
    is_bwd_branch = (i_instruction[6:0] == OP_BRANCH) & i_instruction[31];
    cand_target   = pc_q + (is_jal ? j_imm : b_imm);
    predict_taken = BRANCH_PREDICTION & (is_jal | is_bwd_branch)
                  & (cand_target[1:0] == 2'b00);
    push_entry = '{instr:  i_instruction,
                   pc:     pc_q,
                   pred:   predict_taken,
                   target: predict_taken ? cand_target : 32'h0};
  end

  // NOTE: every variable starts from its held value before the branches so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      // Flush: any ack and any pop this cycle are discarded.
      pc_d     = trap ? i_pc_trap : i_pc_target;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) begin
        pc_d     = predict_taken ? cand_target : pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      case ({accept, pop})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q     <= RESET_ADDR;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; entries are only
  // observable once counted in, and the head outputs are masked when empty.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_rv_fetch_q.sv
// -----------------------------------------------------------------------------
// tb_rv_fetch_q -- self-checking bench for rv_fetch_q.
//
// Two instances share all inputs: dut 0 uses default parameters, dut 1 uses a
// 2-entry queue, no prediction, no Zicsr and a non-zero reset address. A
// queue-based behavioural model of each instance is compared against the DUT
// outputs on every falling edge; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_rv_fetch_q;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
  } ent_t;

  logic        clk;
  logic        i_reset, i_pc_select, i_ebreak, i_ack, i_ready;
  logic [31:0] i_pc_target, i_pc_trap, i_instruction;

  logic [31:0] addr_a, instr_a, pc_a, tgt_a;
  logic        cyc_a, valid_a, pred_a;
  logic [2:0]  count_a;
  logic [31:0] addr_b, instr_b, pc_b, tgt_b;
  logic        cyc_b, valid_b, pred_b;
  logic [1:0]  count_b;

  int errors = 0;
  int checks = 0;

  ent_t        qa[$];
  ent_t        qb[$];
  logic [31:0] pc_m [2];

  rv_fetch_q dut_a (
    .i_clk(clk), .i_reset(i_reset),
    .i_pc_select(i_pc_select), .i_pc_target(i_pc_target),
    .i_ebreak(i_ebreak), .i_pc_trap(i_pc_trap),
    .i_instruction(i_instruction), .i_ack(i_ack),
    .o_addr(addr_a), .o_cyc(cyc_a), .o_valid(valid_a), .i_ready(i_ready),
    .o_instruction(instr_a), .o_pc(pc_a), .o_branch_pred(pred_a),
    .o_pred_target(tgt_a), .o_count(count_a)
  );

  rv_fetch_q #(
    .RESET_ADDR(32'h0000_0100), .BUF_DEPTH_LOG2(1),
    .BRANCH_PREDICTION(1'b0), .EXTENSION_Zicsr(1'b0)
  ) dut_b (
    .i_clk(clk), .i_reset(i_reset),
    .i_pc_select(i_pc_select), .i_pc_target(i_pc_target),
    .i_ebreak(i_ebreak), .i_pc_trap(i_pc_trap),
    .i_instruction(i_instruction), .i_ack(i_ack),
    .o_addr(addr_b), .o_cyc(cyc_b), .o_valid(valid_b), .i_ready(i_ready),
    .o_instruction(instr_b), .o_pc(pc_b), .o_branch_pred(pred_b),
    .o_pred_target(tgt_b), .o_count(count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  // Static prediction rule from the ISA fields: JAL always, conditional
  // branch only with a negative offset, and only for word-aligned targets.
  task automatic predict(input logic [31:0] w, input logic [31:0] pc, input bit bp,
                         output logic pred, output logic [31:0] tgt);
    int          off;
    bit          cand;
    logic [31:0] t;
    cand = 1'b0;
    t    = 32'h0;
    off  = 0;
    if (w[6:0] == 7'b1101111) begin
      off  = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
      cand = 1'b1;
    end else if (w[6:0] == 7'b1100011) begin
      off  = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
      cand = (off < 0);
    end
    t    = pc + 32'(off);
    pred = bp && cand && (t[1:0] == 2'b00);
    tgt  = pred ? t : 32'h0;
  endtask

  // One cycle of the reference model for instance k: check outputs against
  // the model state and current inputs, then advance the model past the edge.
  task automatic step(input int k, input logic cyc, input logic [31:0] addr,
                      input logic valid, input logic [31:0] instr,
                      input logic [31:0] pc, input logic pred,
                      input logic [31:0] tgt, input int unsigned cnt);
    ent_t        q[$];
    ent_t        head, e;
    bit          trap, redirect, e_cyc, e_valid, bp, zc;
    int          depth;
    logic [31:0] raddr;
    depth = (k == 0) ? 4 : 2;
    bp    = (k == 0);
    zc    = (k == 0);
    raddr = (k == 0) ? 32'h0 : 32'h100;
    if (k == 0) q = qa; else q = qb;
    if (i_reset) begin
      check("rst_cyc",   k, 32'(cyc),   32'h0);
      check("rst_addr",  k, addr,       raddr);
      check("rst_valid", k, 32'(valid), 32'h0);
      check("rst_count", k, cnt,        32'h0);
      check("rst_instr", k, instr,      NOP);
      check("rst_pc",    k, pc,         32'h0);
      q.delete();
      pc_m[k] = raddr;
    end else begin
      trap     = zc && i_ebreak;
      redirect = trap || i_pc_select;
      e_cyc    = !redirect && (q.size() < depth);
      e_valid  = !redirect && (q.size() != 0);
      head     = e_valid ? q[0] : '{instr: NOP, pc: 32'h0, tgt: 32'h0, pred: 1'b0};
      check("cyc",   k, 32'(cyc),   32'(e_cyc));
      check("addr",  k, addr,       pc_m[k]);
      check("valid", k, 32'(valid), 32'(e_valid));
      check("count", k, cnt,        32'(q.size()));
      check("instr", k, instr,      head.instr);
      check("pc",    k, pc,         head.pc);
      check("pred",  k, 32'(pred),  32'(head.pred));
      check("tgt",   k, tgt,        head.tgt);
      if (redirect) begin
        q.delete();
        pc_m[k] = trap ? i_pc_trap : i_pc_target;
      end else begin
        if (e_valid && i_ready) void'(q.pop_front());
        if (e_cyc && i_ack) begin
          e.instr = i_instruction;
          e.pc    = pc_m[k];
          predict(i_instruction, pc_m[k], bp, e.pred, e.tgt);
          q.push_back(e);
          pc_m[k] = e.pred ? e.tgt : pc_m[k] + 32'd4;
        end
      end
    end
    if (k == 0) qa = q; else qb = q;
  endtask

  always @(negedge clk) begin
    step(0, cyc_a, addr_a, valid_a, instr_a, pc_a, pred_a, tgt_a, 32'(count_a));
    step(1, cyc_b, addr_b, valid_b, instr_b, pc_b, pred_b, tgt_b, 32'(count_b));
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Redirect to 'at', return 'word' there, then check the predecode result.
  task automatic branch_case(input logic [31:0] at, input logic [31:0] word,
                             input logic [31:0] a_addr, input logic a_pred,
                             input logic [31:0] a_tgt, input logic [31:0] b_addr);
    next_cycle();
    i_pc_select = 1'b1; i_pc_target = at; i_ack = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    next_cycle();
    i_pc_select = 1'b0; i_instruction = word; i_ack = 1'b1;
    @(negedge clk);
    check("br_req_addr", 0, addr_a, at);
    next_cycle();
    i_ack = 1'b0;
    @(negedge clk);
    check("br_next_addr", 0, addr_a,       a_addr);
    check("br_head_pc",   0, pc_a,         at);
    check("br_pred",      0, 32'(pred_a),  32'(a_pred));
    check("br_tgt",       0, tgt_a,        a_tgt);
    check("br_next_addr", 1, addr_b,       b_addr);
    check("br_pred",      1, 32'(pred_b),  32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom & 32'h0000_0FFC;
    if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFF8;
    if ($urandom_range(0, 7) == 0)  a[1:0] = 2'($urandom);
    return a;
  endfunction

  initial begin
    pc_m[0] = 32'h0;
    pc_m[1] = 32'h100;
    i_reset = 1'b1; i_pc_select = 1'b0; i_pc_target = 32'h0;
    i_ebreak = 1'b0; i_pc_trap = 32'h0; i_instruction = NOP;
    i_ack = 1'b0; i_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_cyc",   0, 32'(cyc_a),   32'h0);
    check("reset_addr",  0, addr_a,       32'h0);
    check("reset_count", 0, 32'(count_a), 32'h0);
    check("reset_instr", 0, instr_a,      NOP);
    check("reset_addr",  1, addr_b,       32'h100);

    // Streaming after reset release: 0,4,8,C
    next_cycle();
    i_reset = 1'b0; i_ack = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    check("stream_cyc0",   0, 32'(cyc_a),   32'h1);
    check("stream_addr0",  0, addr_a,       32'h0);
    check("stream_valid0", 0, 32'(valid_a), 32'h0);
    next_cycle(); @(negedge clk);
    check("stream_addr1",  0, addr_a,       32'h4);
    check("stream_valid1", 0, 32'(valid_a), 32'h1);
    check("stream_pc1",    0, pc_a,         32'h0);
    next_cycle(); @(negedge clk);
    check("stream_addr2",  0, addr_a,       32'h8);
    check("stream_pc2",    0, pc_a,         32'h4);
    next_cycle(); @(negedge clk);
    check("stream_addr3",  0, addr_a,       32'hC);
    check("stream_pc3",    0, pc_a,         32'h8);

    // Fill the 4-entry queue with decode stalled
    next_cycle();
    i_pc_select = 1'b1; i_pc_target = 32'h40; i_ready = 1'b0;
    @(negedge clk);
    check("redir_cyc",   0, 32'(cyc_a),   32'h0);
    check("redir_valid", 0, 32'(valid_a), 32'h0);
    next_cycle();
    i_pc_select = 1'b0;
    @(negedge clk);
    repeat (4) begin next_cycle(); @(negedge clk); end
    check("full_count", 0, 32'(count_a), 32'h4);
    check("full_cyc",   0, 32'(cyc_a),   32'h0);
    check("full_addr",  0, addr_a,       32'h50);
    check("full_head",  0, pc_a,         32'h40);
    next_cycle();
    i_ready = 1'b1;
    @(negedge clk);
    check("pop_count_pre", 0, 32'(count_a), 32'h4);
    next_cycle();
    i_ready = 1'b0;
    @(negedge clk);
    check("pop_count", 0, 32'(count_a), 32'h3);
    check("pop_cyc",   0, 32'(cyc_a),   32'h1);
    check("pop_head",  0, pc_a,         32'h44);

    // Predecode cases
    branch_case(32'h10, 32'hFE00_0EE3, 32'h0C,  1'b1, 32'h0C,  32'h14);
    branch_case(32'h10, 32'h0000_0463, 32'h14,  1'b0, 32'h0,   32'h14);
    branch_case(32'h20, 32'h1000_006F, 32'h120, 1'b1, 32'h120, 32'h24);

    // Redirect while 3 entries queued, with ack and pop in the same cycle
    next_cycle();
    i_pc_select = 1'b1; i_pc_target = 32'h300; i_ack = 1'b0; i_ready = 1'b0;
    i_instruction = NOP;
    @(negedge clk);
    next_cycle();
    i_pc_select = 1'b0; i_ack = 1'b1;
    @(negedge clk);
    repeat (3) begin next_cycle(); @(negedge clk); end
    check("flush_pre_count", 0, 32'(count_a), 32'h3);
    next_cycle();
    i_pc_select = 1'b1; i_pc_target = 32'h200; i_ready = 1'b1;
    @(negedge clk);
    check("flush_valid", 0, 32'(valid_a), 32'h0);
    check("flush_cyc",   0, 32'(cyc_a),   32'h0);
    next_cycle();
    i_pc_select = 1'b0; i_ack = 1'b0; i_ready = 1'b0;
    @(negedge clk);
    check("flush_count", 0, 32'(count_a), 32'h0);
    check("flush_addr",  0, addr_a,       32'h200);

    // Trap versus execute redirect
    next_cycle();
    i_ebreak = 1'b1; i_pc_trap = 32'h80; i_pc_select = 1'b1; i_pc_target = 32'h200;
    @(negedge clk);
    next_cycle();
    i_ebreak = 1'b0; i_pc_select = 1'b0;
    @(negedge clk);
    check("trap_addr", 0, addr_a, 32'h80);
    check("trap_addr", 1, addr_b, 32'h200);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      next_cycle();
      i_reset     = ($urandom_range(0, 249) == 0);
      i_pc_select = ($urandom_range(0, 29) == 0);
      i_ebreak    = ($urandom_range(0, 39) == 0);
      i_pc_target = rand_addr();
      i_pc_trap   = rand_addr();
      i_ack       = ($urandom_range(0, 9) < 7);
      i_ready     = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 3))
        0:       i_instruction = {$urandom, 7'b1101111} ;
        1:       i_instruction = {$urandom, 7'b1100011} ;
        2:       i_instruction = {1'b1, 24'($urandom), 7'b1100011};
        default: i_instruction = $urandom;
      endcase
    end

    next_cycle();
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_fetch_q.md
# rv_fetch_q

Parametrised fetch stage with a decoupled instruction queue, an elastic valid/ready handshake to decode, and static branch prediction.

- Issues single-word requests on the instruction bus.
- Buffers returned words in a FIFO of configurable depth.
- Predecodes each word to redirect fetch on JAL and on backward conditional branches.
- Sits between the instruction bus/cache and decode; takes redirects from execute (branch resolve) and from the CSR unit (trap).

## Interface
Parameters:
- RESET_ADDR, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH_LOG2, 2, queue depth = 2**BUF_DEPTH_LOG2 entries (legal 1..5).
- BRANCH_PREDICTION, 1, 1 = static predictor active; 0 = always fall through (pc+4).
- EXTENSION_Zicsr, 1, 0 = i_ebreak/i_pc_trap ignored.

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_pc_select  in  1  execute redirect request.
- i_pc_target  in  32  redirect address.
- i_ebreak  in  1  trap redirect request.
- i_pc_trap  in  32  trap vector.
- i_instruction  in  32  bus read data, valid when i_ack=1.
- i_ack  in  1  bus completes the current request this cycle.
- o_addr  out  32  bus address (current fetch pc).
- o_cyc  out  1  bus request.
- o_valid  out  1  queue head valid to decode.
- i_ready  in  1  decode accepts head.
- o_instruction  out  32  head instruction.
- o_pc  out  32  head pc.
- o_branch_pred  out  1  head was predicted taken.
- o_pred_target  out  32  predicted target of head (0 if not predicted).
- o_count  out  BUF_DEPTH_LOG2+1  queue occupancy.

## Operation
- Redirect priority: i_reset > (i_ebreak & EXTENSION_Zicsr) > i_pc_select. Redirect is the OR of the last two.
- Redirect cycle:
  - o_cyc=0 and o_valid=0 (combinational).
  - Any i_ack in that cycle is discarded.
  - At the edge: queue emptied, fetch pc loaded with i_pc_trap or i_pc_target.
- Request: o_cyc = !i_reset & !redirect & (o_count < DEPTH); o_addr = fetch pc.
  - At most one outstanding request.
  - o_addr stays stable until i_ack or redirect; dropping o_cyc aborts the request.
- Accept = o_cyc & i_ack. On accept, push {i_instruction, fetch pc, pred, target} and update fetch pc:
  - JAL (opcode 1101111): target = pc + J-imm.
  - Branch (opcode 1100011) with imm[12]=1: target = pc + B-imm.
  - Predict taken only if BRANCH_PREDICTION=1 and target[1:0]==0. Then fetch pc ← target, pred=1.
  - Otherwise fetch pc ← pc+4 (wraps modulo 2^32), pred=0, target=0.
  - JALR is never predicted.
- Pop on o_valid & i_ready.
  - Simultaneous push and pop leaves o_count unchanged.
  - Push never occurs when full, because o_cyc=0 when full.
- o_valid = (o_count != 0) & !redirect.
- When o_valid=0: o_instruction=32'h0000_0013 (NOP), o_pc=0, o_branch_pred=0, o_pred_target=0.
- Pointers are BUF_DEPTH_LOG2 bits and wrap naturally. The count is one bit wider so full and empty are distinct.

## Timing
- Reset values (asynchronous) while i_reset=1:
  - fetch pc = RESET_ADDR, o_addr = RESET_ADDR.
  - o_cyc=0, o_valid=0, o_count=0.
  - Head outputs at the empty values above.
- First cycle after reset release: o_cyc=1, o_addr=RESET_ADDR.
- Reset asserted mid-request aborts the request; no write occurs.
- Accept in cycle N:
  - Entry visible at the head in N+1 (o_valid=1 if the queue was empty).
  - o_addr shows the next or predicted pc in N+1.
- Throughput: 1 word/cycle when i_ack is held high and decode pops every cycle.
- Predicted-taken costs no bubble: the target is requested in the cycle after the branch word is accepted.
- Redirect in cycle N: first request to the new address in N+1; earliest o_valid in N+2 with a zero-wait bus.
- Simultaneous redirect and pop: the pop is suppressed (o_valid=0), and the queue is cleared anyway.
- Simultaneous i_ebreak and i_pc_select: the trap vector wins when EXTENSION_Zicsr=1.

## Test plan
- Reset release, i_ack=1 every cycle, i_ready=1:
  - o_addr sequence is 0,4,8,C.
  - o_valid rises one cycle after the first ack; o_pc follows 0,4,8.
- i_ready=0, DEPTH=4:
  - Exactly 4 accepts, o_count reaches 4, o_cyc drops to 0.
  - Then one pop gives o_count=3 and o_cyc=1 in the same cycle.
- Word 32'hFE000EE3 (beq x0,x0,-4) at pc 0x10:
  - Next o_addr=0x0C.
  - Head entry has o_branch_pred=1, o_pred_target=0x0C.
  - Same test with forward offset +8: next addr 0x14, pred=0.
- JAL with offset +0x100 at 0x20: next o_addr=0x120, pred=1.
  - BRANCH_PREDICTION=0: next addr 0x24, pred=0.
- Queue holding 3 entries, i_pc_select=1 with target 0x200 and i_ack=1 in the same cycle:
  - o_valid=0 and o_cyc=0 that cycle, the ack is dropped.
  - Next cycle o_count=0, o_addr=0x200.
- i_ebreak=1 with i_pc_trap=0x80, same cycle i_pc_select with 0x200:
  - Next o_addr=0x80.
  - EXTENSION_Zicsr=0: next o_addr=0x200.
